// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ valid/ready producers.
// Latency: a grant starts one cycle after valid in IDLE, with zero-cycle handover; the data path is combinational.
// Backpressure: fifo_full clears the owner's ready in the same cycle; the grant and burst count are held.
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       fifo_full_i,
  output logic                       fifo_write_o,
  output logic [WIDTH-1:0]           fifo_data_in_o,
  output logic                       grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic [15:0]                stall_cycles_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST) + 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  logic           state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic [15:0]    stall_q, stall_d;

  logic           in_grant;
  logic           owner_vld;
  logic           xfer;
  logic           release_grant;
  logic [IDW-1:0] owner_inc;
  logic [IDW-1:0] arb_base;
  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] cand_idx;
  int             cand;

  assign in_grant  = (state_q == ST_GRANT);
  assign owner_vld = in_grant && req_valid_i[owner_q];
  assign xfer      = owner_vld && !fifo_full_i;

  // A burst ends on its last beat or as soon as the owner stops offering data.
  assign release_grant = in_grant &&
                         (!req_valid_i[owner_q] || (xfer && (burst_cnt_q == LAST_BEAT)));

  assign owner_inc = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);

  // On release the search starts just past the old owner, so it ranks last.
  assign arb_base = in_grant ? owner_inc : rr_ptr_q;

  // Pick the first valid requester at or after arb_base, wrapping modulo NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(arb_base) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDW'(cand);
      if (req_valid_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  // Next state: arbitrate when idle or releasing, otherwise count beats of the held burst.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (!in_grant || release_grant) begin
      if (release_grant) begin
        rr_ptr_d = owner_inc;
      end
      burst_cnt_d = '0;
      if (sel_found) begin
        state_d = ST_GRANT;
        owner_d = sel_idx;
      end else begin
        state_d = ST_IDLE;
        owner_d = '0;
      end
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + BCW'(1);
    end
  end

  // Count cycles where the owner had data but the FIFO was full, saturating at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (owner_vld && fifo_full_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers; reset abandons any burst and restarts arbitration from index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      stall_q     <= stall_d;
    end
  end

  // Only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready_o = '0;
    if (in_grant) begin
      req_ready_o[owner_q] = !fifo_full_i;
    end
  end

  assign fifo_write_o   = xfer;
  assign fifo_data_in_o = in_grant ? req_data_i[owner_q*WIDTH +: WIDTH] : '0;
  assign grant_valid_o  = in_grant;
  assign grant_id_o     = owner_q;
  assign stall_cycles_o = stall_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized and directed stimulus for fifo_write_arbiter with a behavioural reference model.
// Per-producer scoreboards hold the words each producer offered; a negedge monitor checks every cycle.
// Producers follow the DUT handshake; all expected values come from the model and scoreboards.
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  typedef logic [W-1:0] word_q_t[$];

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_data = '0;
  logic            fifo_full = 1'b0;

  logic [NR-1:0]   req_ready_o;
  logic            fifo_write_o;
  logic [W-1:0]    fifo_data_in_o;
  logic            grant_valid_o;
  logic [1:0]      grant_id_o;
  logic [15:0]     stall_cycles_o;

  fifo_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready_o),
    .fifo_full_i   (fifo_full),
    .fifo_write_o  (fifo_write_o),
    .fifo_data_in_o(fifo_data_in_o),
    .grant_valid_o (grant_valid_o),
    .grant_id_o    (grant_id_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  word_q_t       src_q[NR];
  word_q_t       exp_q[NR];
  logic [NR-1:0] valid_en = '1;
  logic [NR-1:0] acc_pend = '0;
  int            wr_cnt[NR];
  int            wr_log[$];
  int            checks = 0;
  int            passes = 0;

  // Reference model: who owns the port, where the next search starts, beats used, stall count.
  int m_grant, m_owner, m_ptr, m_cnt, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_grant = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model across the coming edge.
  task automatic model_cycle();
    bit xfer, fin, found;
    int start, c;
    chk("grant_valid", grant_valid_o, m_grant);
    chk("grant_id", grant_id_o, m_grant ? m_owner : 0);
    chk("req_ready", req_ready_o, (m_grant && !fifo_full) ? (1 << m_owner) : 0);
    xfer = m_grant && req_valid[m_owner] && !fifo_full;
    chk("fifo_write", fifo_write_o, xfer);
    chk("fifo_data_in", fifo_data_in_o, m_grant ? req_data[m_owner*W +: W] : 0);
    chk("stall_cycles", stall_cycles_o, m_stall);
    if (m_grant && req_valid[m_owner] && fifo_full && m_stall < 65535) m_stall++;
    fin = m_grant && (!req_valid[m_owner] || (xfer && m_cnt == MB - 1));
    if (m_grant && !fin) begin
      if (xfer) m_cnt++;
    end else begin
      start = m_grant ? (m_owner + 1) % NR : m_ptr;
      m_ptr = start;
      found = 0;
      for (int k = 0; k < NR && !found; k++) begin
        c = (start + k) % NR;
        if (req_valid[c]) begin found = 1; m_owner = c; end
      end
      m_grant = found;
      m_cnt = 0;
      if (!found) m_owner = 0;
    end
  endtask

  // Monitor: model check every cycle, then score any accepted word against its producer's queue.
  always @(negedge clk) begin
    logic [NR-1:0] a;
    int idx;
    if (reset) begin
      chk("rst_ready", req_ready_o, 0);
      chk("rst_write", fifo_write_o, 0);
      chk("rst_data", fifo_data_in_o, 0);
      chk("rst_gvalid", grant_valid_o, 0);
      chk("rst_gid", grant_id_o, 0);
      chk("rst_stall", stall_cycles_o, 0);
      model_reset();
      acc_pend = '0;
    end else begin
      model_cycle();
      a = req_ready_o & req_valid;
      acc_pend = a;
      if (a != 0 && !fifo_write_o) begin
        chk("accept_has_write", fifo_write_o, 1);
      end else if (fifo_write_o) begin
        if ($countones(a) != 1) begin
          chk("write_has_accept", $countones(a), 1);
        end else begin
          idx = 0;
          for (int i = 0; i < NR; i++) if (a[i]) idx = i;
          chk("sb_has_word", exp_q[idx].size() > 0, 1);
          if (exp_q[idx].size() > 0) begin
            chk("fifo_data_sb", fifo_data_in_o, exp_q[idx].pop_front());
            wr_cnt[idx]++;
            wr_log.push_back(idx);
          end
        end
      end
    end
  end

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = valid_en[i] && (src_q[i].size() > 0);
      req_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // Advance one clock; producers retire the words the DUT accepted at that edge.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NR; i++) if (acc_pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    acc_pend = '0;
  endtask

  task automatic run(input int n);
    repeat (n) begin tick(); apply(); end
  endtask

  task automatic add_words(input int p, input int n, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) begin
      src_q[p].push_back(base + W'(k));
      exp_q[p].push_back(base + W'(k));
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NR; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    valid_en = '1;
    fifo_full = 1'b0;
    apply();
    while (pending() > 0 && n < budget) begin tick(); apply(); n++; end
    chk("drain_done", pending(), 0);
    tick();
    apply();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      wr_cnt[i] = 0;
    end
    wr_log.delete();
    valid_en = '1;
    fifo_full = 1'b0;
    apply();
    tick();
    tick();
    reset = 1'b0;
    apply();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) wr_cnt[i] = 0;
    model_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Single producer: two bursts back to back with no bubble.
    tick();
    add_words(2, 6, 8'hA0);
    apply();
    run(12);
    chk("p1_writes", wr_cnt[2], 6);

    // Round robin with every producer continuously valid.
    do_reset();
    for (int i = 0; i < NR; i++) add_words(i, 2 * MB, W'(8'h10 * (i + 1)));
    apply();
    drain(100);
    chk("rr_count", wr_log.size(), 2 * MB * NR);
    for (int k = 0; k < wr_log.size() && k < 2 * MB * NR; k++) chk("rr_order", wr_log[k], (k / MB) % NR);

    // Full backpressure for five cycles in the middle of producer 1's burst.
    do_reset();
    add_words(1, 8, 8'h50);
    apply();
    run(2);
    tick();
    fifo_full = 1'b1;
    apply();
    run(4);
    tick();
    fifo_full = 1'b0;
    apply();
    chk("stall_5", stall_cycles_o, 5);
    drain(50);
    chk("bp_writes", wr_cnt[1], 8);

    // Early release: producer 0 sends one word then drops valid; producer 3 takes over.
    do_reset();
    add_words(0, 4, 8'h00);
    add_words(3, 3, 8'h30);
    apply();
    run(1);
    tick();
    valid_en[0] = 1'b0;
    apply();
    tick();
    apply();
    chk("early_gid", grant_id_o, 3);
    chk("early_w0", wr_cnt[0], 1);
    drain(50);

    // Reset while producer 2 presents its second word.
    do_reset();
    add_words(2, 4, 8'hC0);
    apply();
    run(1);
    tick();
    reset = 1'b1;
    apply();
    #1;
    chk("mid_rst_write", fifo_write_o, 0);
    chk("mid_rst_gvalid", grant_valid_o, 0);
    chk("mid_rst_ready", req_ready_o, 0);
    chk("mid_rst_data", fifo_data_in_o, 0);
    run(2);
    tick();
    reset = 1'b0;
    add_words(0, 2, 8'hD0);
    add_words(1, 2, 8'hD4);
    add_words(3, 2, 8'hDC);
    wr_log.delete();
    apply();
    drain(60);
    chk("post_rst_first", (wr_log.size() > 0) ? wr_log[0] : -1, 0);

    // Stall counter saturation.
    do_reset();
    add_words(1, 2, 8'h60);
    fifo_full = 1'b1;
    apply();
    run(70000);
    chk("stall_sat", stall_cycles_o, 16'hFFFF);
    drain(20);
    chk("stall_sat_hold", stall_cycles_o, 16'hFFFF);

    // Random traffic, valid drops and backpressure.
    do_reset();
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 2) == 0) begin
        int p;
        logic [W-1:0] w;
        p = $urandom_range(0, NR - 1);
        w = W'($urandom);
        src_q[p].push_back(w);
        exp_q[p].push_back(w);
      end
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 7) == 0) valid_en[i] = ~valid_en[i];
      fifo_full = ($urandom_range(0, 3) == 0);
      apply();
    end
    drain(600);
    for (int i = 0; i < NR; i++) chk("sb_empty", exp_q[i].size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words, steers that producer's data onto the FIFO write port, and stalls on FIFO full. It sits directly in front of the FIFO's write/data_in/full pins.

## Interface
- NUM_REQ, 4: number of producers, 2..8
- WIDTH, 8: data word width, equal to FIFO width
- MAX_BURST, 4: max consecutive writes per grant, 1..16
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  producer i has a word on req_data slice i
- req_data  in  NUM_REQ*WIDTH  producer i word at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot or zero; word i accepted when valid[i]&&ready[i] at posedge
- fifo_full  in  1  FIFO full flag, valid in the cycle it is sampled
- fifo_write  out  1  FIFO write strobe
- fifo_data_in  out  WIDTH  FIFO write data
- grant_valid  out  1  a producer currently owns the port
- grant_id  out  $clog2(NUM_REQ)  current owner index
- stall_cycles  out  16  saturating count of cycles the owner had valid high while fifo_full was high

## Operation
- State is registered: state (IDLE/GRANT), owner, rr_ptr, burst_cnt ($clog2(MAX_BURST)+1 bits), stall_cycles.
- IDLE:
  - If any req_valid is high, select the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: state=GRANT, owner=selected, burst_cnt=0.
  - If no req_valid is high, stay in IDLE.
- GRANT:
  - req_ready[owner] = !fifo_full (combinational). All other ready bits are 0.
  - fifo_write = req_valid[owner] && req_ready[owner]. fifo_data_in = req_data slice owner, driven combinationally at all times in GRANT; it is 0 in IDLE.
  - On a transfer, burst_cnt increments.
- Release from GRANT occurs on either of two conditions:
  - A transfer with burst_cnt==MAX_BURST-1.
  - req_valid[owner]==0 at the clock edge.
- On release:
  - rr_ptr becomes owner+1 mod NUM_REQ.
  - Re-arbitrate in the same edge using the new rr_ptr, so the old owner has the lowest priority.
  - If a candidate exists: GRANT to that candidate, burst_cnt=0, with no idle bubble.
  - Otherwise: IDLE.
- fifo_full high in GRANT:
  - No transfer occurs; the owner keeps the grant; burst_cnt is held.
  - There is no timeout.
- stall_cycles increments on each clk where state==GRANT && req_valid[owner] && fifo_full. It saturates at 16'hFFFF.
- grant_valid = (state==GRANT). grant_id = owner, which is 0 in IDLE.

## Timing
- Reset, async assert: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, stall_cycles=0.
  - Outputs during reset: req_ready=0, fifo_write=0, fifo_data_in=0, grant_valid=0, grant_id=0.
- Reset mid-burst: the burst is abandoned and no write is issued while reset is high. After release, arbitration restarts from index 0.
- Arbitration latency: valid rising in IDLE at edge N gives grant from N+1. The first transfer can occur at edge N+1.
- Handover latency: 0 cycles. A new owner can transfer at the edge right after the previous owner's final transfer.
- Data path FIFO-side is combinational: fifo_write/fifo_data_in follow req_valid/req_data/fifo_full in the same cycle.
- fifo_full rises during a burst: a write is suppressed in that same cycle. Transfers resume the cycle fifo_full falls.
- Producer drops valid mid-burst: the grant is released at that edge, and the remaining burst budget is forfeited.
- MAX_BURST=1: ownership rotates after every word.
- Every accepted word produces exactly one fifo_write. No word is written twice; no word is dropped.

## Test plan
- Single producer: after reset, valid[2] held high with data 0xA0..0xA5, MAX_BURST=4, fifo_full=0.
  - Expect grant_id=2 one cycle later, writes 0xA0–0xA3.
  - Then release, re-grant to 2 with no bubble (sole candidate), writes 0xA4–0xA5.
- Round-robin fairness: all four producers continuously valid, MAX_BURST=2.
  - Expect grant order 0,1,2,3,0 and two writes each, with zero bubbles between bursts.
- Full backpressure: producer 1 granted, fifo_full=1 for 5 cycles mid-burst.
  - Expect fifo_write=0 and req_ready=0 for those cycles, and stall_cycles=5.
  - Burst then resumes with burst_cnt unchanged.
- Early release: producer 0 sends 1 word then drops valid while producer 3 is valid.
  - Expect one write from 0, then grant_id=3 at the next edge, with rr_ptr having advanced to 1.
- Reset mid-burst: assert reset during producer 2's second word.
  - Expect all outputs 0 immediately and no fifo_write during reset.
  - After release with all valid, the first grant goes to producer 0.
- Saturation: hold owner valid with fifo_full=1 for 70000 cycles.
  - Expect stall_cycles=16'hFFFF with no wrap.
